// File: rtl/bidir_bus_pkg.sv
// Shared types and constants for the bidirectional bus scheduler.
// Holds the controller state encoding, the read-side descramble key and
// the default bus width.
package bidir_bus_pkg;

  localparam int DW_DEFAULT = 4;

  // Key the device uses to scramble read data; applied again on sample to undo it.
  localparam logic [3:0] RD_KEY = 4'b1010;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WR,
    RD_WAIT_S,
    RD_SAMP,
    GAP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search begins one position after ptr and wraps, so the requester that
// won last time has the lowest priority. Returns a one-hot winner, its index
// and a valid flag.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] cand;

  // Walk the requesters from ptr+1 and keep the first one asking.
  always_comb begin
    gnt_oh = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bidir_bus_sched.sv
// Round-robin scheduler sharing one bidirectional device port between
// NREQ requesters. A single register bit drives both the device direction
// select and the controller tristate enable, so the two can never disagree.
// Optional build macro: BIDIR_BUS_SCHED_RD_DECODE_EN -- when defined, the
// sampled read data is XORed with RD_KEY to undo device-side scrambling.
module bidir_bus_sched
  import bidir_bus_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int NREQ    = 2,
  parameter int RD_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  we,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic             done,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic             io_sel,
  inout  wire  [DW-1:0]    bus_io
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 3;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   wr_q, wr_d;
  logic            drv_q, drv_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;

  function automatic logic [DW-1:0] rd_decode(input logic [DW-1:0] raw);
`ifdef BIDIR_BUS_SCHED_RD_DECODE_EN
    return raw ^ DW'(RD_KEY);
`else
    return raw;
`endif
  endfunction

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .gnt_oh (arb_oh),
    .idx    (arb_idx),
    .valid  (arb_vld)
  );

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    drv_d   = drv_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d   = arb_oh;
          ptr_d   = arb_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // ptr already names the granted requester; latch its op and data now.
        wr_d = wdata[ptr_q*DW +: DW];
        if (we[ptr_q]) begin
          drv_d   = 1'b1;
          state_d = WR;
        end else begin
          cnt_d   = CW'(RD_WAIT - 1);
          state_d = RD_WAIT_S;
        end
      end
      WR: begin
        drv_d   = 1'b0;
        done_d  = 1'b1;
        state_d = GAP;
      end
      RD_WAIT_S: begin
        if (cnt_q == '0) begin
          state_d = RD_SAMP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_SAMP: begin
        // Captured as-is, including any undriven value; the bench flags those.
        rdata_d = rd_decode(bus_io);
        done_d  = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        drv_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Control state; the async reset drops the drive enable immediately, even mid-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      drv_q   <= 1'b0;
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      drv_q   <= drv_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write data holding register; only visible while the drive enable is set.
  always_ff @(posedge clk) begin
    wr_q <= wr_d;
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign busy   = (state_q != IDLE);
  assign io_sel = drv_q;
  assign bus_io = drv_q ? wr_q : {DW{1'bz}};

endmodule

// File: tb/tb_bidir_bus_sched.sv
// Bench for bidir_bus_sched: a transaction-level model (cycle age since
// grant) plus a tiny device that captures on io_sel=1 and returns reg^A.
module tb_bidir_bus_sched;

  localparam int DW      = 4;
  localparam int NREQ    = 2;
  localparam int RD_WAIT = 1;

`ifdef BIDIR_BUS_SCHED_RD_DECODE_EN
  localparam logic [3:0] EXP_RD1 = 4'h6;
  localparam logic [3:0] EXP_RD2 = 4'h3;
`else
  localparam logic [3:0] EXP_RD1 = 4'hC;
  localparam logic [3:0] EXP_RD2 = 4'h9;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   we = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt;
  logic              done;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic              io_sel;
  wire  [DW-1:0]     bus_io;

  int total = 0;
  int bad   = 0;
  int io_cnt = 0;

  bidir_bus_sched #(
    .DW      (DW),
    .NREQ    (NREQ),
    .RD_WAIT (RD_WAIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .wdata  (wdata),
    .gnt    (gnt),
    .done   (done),
    .rdata  (rdata),
    .busy   (busy),
    .io_sel (io_sel),
    .bus_io (bus_io)
  );

  always #5 clk = ~clk;

  // Device: captures the bus when io_sel=1, drives reg^A while the controller reads.
  logic [3:0] dev_reg = 4'h0;
  logic       dev_oe;
  assign dev_oe = !io_sel && busy;
  assign bus_io = dev_oe ? (dev_reg ^ 4'hA) : 4'bzzzz;
  always @(posedge clk) if (io_sel) dev_reg <= bus_io;

  // Model state: one transaction in flight, tracked by its age in cycles since grant.
  bit         m_act = 1'b0;
  int         m_own = 0;
  int         m_ptr = NREQ - 1;
  int         m_age = 0;
  bit         m_wr  = 1'b0;
  logic [3:0] m_wd  = 4'h0;
  logic [3:0] m_dev = 4'h0;
  logic [3:0] m_rdata = 4'h0;

  function automatic logic [3:0] model_read(input logic [3:0] dev);
    logic [3:0] raw;
    raw = dev ^ 4'hA;
`ifdef BIDIR_BUS_SCHED_RD_DECODE_EN
    raw = raw ^ 4'hA;
`endif
    return raw;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int w;
    int len;
    logic [NREQ-1:0] r;
    logic [NREQ*DW-1:0] sh;
    if (!rst_n) begin
      m_act   <= 1'b0;
      m_ptr   <= NREQ - 1;
      m_age   <= 0;
      m_rdata <= 4'h0;
    end else if (!m_act) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        r = req >> ((m_ptr + k) % NREQ);
        if (w < 0 && r[0]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) begin
        m_act <= 1'b1;
        m_own <= w;
        m_ptr <= w;
        m_age <= 1;
      end
    end else begin
      if (m_age == 1) begin
        r  = we >> m_own;
        sh = wdata >> (m_own * DW);
        m_wr <= r[0];
        m_wd <= sh[3:0];
      end
      if (m_wr && m_age == 2) m_dev <= m_wd;
      if (!m_wr && m_age == 2 + RD_WAIT) m_rdata <= model_read(m_dev);
      len = m_wr ? 3 : 3 + RD_WAIT;
      if (m_age >= 2 && m_age == len) m_act <= 1'b0;
      else m_age <= m_age + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic [NREQ-1:0] e_gnt;
    logic e_io, e_done;
    e_gnt  = m_act ? (NREQ'(1) << m_own) : '0;
    e_io   = m_act && m_wr && (m_age == 2);
    e_done = m_act && (m_age >= 2) && (m_age == (m_wr ? 3 : 3 + RD_WAIT));
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(m_act));
    chk("io_sel", 32'(io_sel), 32'(e_io));
    chk("done", 32'(done), 32'(e_done));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (io_sel) begin
      io_cnt++;
      chk("bus_wr", 32'(bus_io), 32'(m_wd));
    end else if (busy) begin
      chk("bus_dev", 32'(bus_io), 32'(m_dev ^ 4'hA));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 32'(n), 32'(0));
  endtask

  initial begin : stim
    int n;
    bit got;
    logic [NREQ-1:0] seq [4];
    logic [NREQ-1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    // Reset state
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_io_sel", 32'(io_sel), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write from requester 0
    io_cnt = 0;
    req = 2'b01; we = 2'b01; wdata = {4'h0, 4'h6};
    wait_done(n);
    chk("wr_latency", 32'(n), 32'd3);
    req = 2'b00;
    tick();
    chk("wr_io_cycles", 32'(io_cnt), 32'd1);
    chk("dev_reg_after_wr", 32'(dev_reg), 32'h6);

    // Read from requester 1
    req = 2'b10; we = 2'b00;
    wait_done(n);
    chk("rd_latency", 32'(n), 32'd4);
    chk("rd_value", 32'(rdata), 32'(EXP_RD1));
    req = 2'b00;
    tick();

    // Both requesting continuously: grants alternate
    req = 2'b11; we = 2'b01; wdata = {4'h5, 4'h3};
    for (int g = 0; g < 4; g++) begin
      wait_done(n);
      seq[g] = gnt;
    end
    req = 2'b00;
    for (int g = 0; g < 4; g++) chk($sformatf("rr_seq%0d", g), 32'(seq[g]), 32'(exp_seq[g]));
    chk("rr_last_rd", 32'(rdata), 32'(EXP_RD2));
    tick();
    tick();

    // Reset in the middle of a write
    req = 2'b01; we = 2'b01; wdata = {4'h5, 4'hF};
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (io_sel) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("wr_start_timeout", 32'd0, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midwr_io_sel", 32'(io_sel), 32'd0);
    chk("midwr_gnt", 32'(gnt), 32'd0);
    chk("midwr_busy", 32'(busy), 32'd0);
    req = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    chk("midwr_dev_reg", 32'(dev_reg), 32'h3);
    req = 2'b11; we = 2'b01;
    tick();
    chk("post_rst_first_gnt", 32'(gnt), 32'b01);
    wait_done(n);
    req = 2'b10;
    wait_done(n);
    chk("post_rst_dev_reg", 32'(dev_reg), 32'hF);
    req = 2'b00;
    tick();
    tick();

    // req[0] dropped right after grant
    req = 2'b01; we = 2'b00;
    tick();
    chk("drop_gnt", 32'(gnt), 32'b01);
    req = 2'b10;
    wait_done(n);
    chk("drop_done_lat", 32'(n), 32'd3);
    tick();
    tick();
    chk("drop_next_gnt", 32'(gnt), 32'b10);
    wait_done(n);
    req = 2'b00;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
